// File: rtl/univ_shift_ctrl.sv
// univ_shift_ctrl: command sequencer for a C_BIT_NUM-bit universal shift
// register ({S0,S1}: 00 hold, 01 shift left, 10 shift right, 11 load).
// Takes LOAD / SHL / SHR / ASR commands over a valid/ready handshake and
// issues the matching mode cycles, then pulses DONE for one cycle.
// Optional feature macro: SHIFT_ROTATE_EN (CMD_ROT turns shifts into rotates).
module univ_shift_ctrl #(
    parameter int C_BIT_NUM = 24,
    parameter int C_CNT_W   = 5
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [1:0]           CMD_OP,
    input  logic [C_CNT_W-1:0]   CMD_CNT,
    input  logic                 CMD_FILL,
    input  logic                 CMD_ROT,
    input  logic [C_BIT_NUM-1:0] LOAD_DATA,
    input  logic [C_BIT_NUM-1:0] Q_IN,
    output logic                 S0,
    output logic                 S1,
    output logic                 SRI,
    output logic                 SLI,
    output logic [C_BIT_NUM-1:0] D,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_SHL  = 2'd1;
    localparam logic [1:0] OP_SHR  = 2'd2;
    localparam logic [1:0] OP_ASR  = 2'd3;

    localparam logic [C_CNT_W-1:0] MAX_CNT = C_CNT_W'(C_BIT_NUM);

    logic [1:0]           state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 fill_q, fill_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [C_CNT_W-1:0]   clampCnt;
    logic [C_BIT_NUM-1:0] data_q, data_d;
    logic                 s0_q, s0_d;
    logic                 s1_q, s1_d;
    logic                 busy_q, busy_d;

`ifdef SHIFT_ROTATE_EN
    logic                 rot_q, rot_d;
    logic                 unusedBits;
    assign unusedBits = ^Q_IN[C_BIT_NUM-2:1];
`else
    logic                 unusedBits;
    assign unusedBits = ^{CMD_ROT, Q_IN[C_BIT_NUM-2:0]};
`endif

    assign clampCnt = (CMD_CNT > MAX_CNT) ? MAX_CNT : CMD_CNT;

    // Next-state logic: command capture in IDLE, cycle counting in SHIFT,
    // and the registered mode/busy outputs decoded from the upcoming state.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef SHIFT_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    op_d   = CMD_OP;
                    fill_d = CMD_FILL;
                    data_d = LOAD_DATA;
                    cnt_d  = clampCnt;
`ifdef SHIFT_ROTATE_EN
                    rot_d  = CMD_ROT;
`endif
                    if (CMD_OP == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (clampCnt != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_FIN;
            end
            ST_SHIFT: begin
                cnt_d = cnt_q - C_CNT_W'(1);
                if (cnt_q <= C_CNT_W'(1)) begin
                    state_d = ST_FIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s0_d   = (state_d == ST_LOAD) || ((state_d == ST_SHIFT) && (op_d != OP_SHL));
        s1_d   = (state_d == ST_LOAD) || ((state_d == ST_SHIFT) && (op_d == OP_SHL));
        busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
    end

    // State and registered outputs; RN low returns to IDLE with a hold mode.
    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            fill_q  <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            busy_q  <= busy_d;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    // Serial fill bits follow the live register contents so sign and rotate
    // fills stay correct on every shift cycle.
    always_comb begin
        SRI = 1'b0;
        SLI = 1'b0;
        if (state_q == ST_SHIFT) begin
            case (op_q)
                OP_SHL: begin
                    SLI = fill_q;
`ifdef SHIFT_ROTATE_EN
                    if (rot_q) SLI = Q_IN[C_BIT_NUM-1];
`endif
                end
                OP_SHR: begin
                    SRI = fill_q;
`ifdef SHIFT_ROTATE_EN
                    if (rot_q) SRI = Q_IN[0];
`endif
                end
                OP_ASR: begin
                    SRI = Q_IN[C_BIT_NUM-1];
`ifdef SHIFT_ROTATE_EN
                    if (rot_q) SRI = Q_IN[0];
`endif
                end
                default: begin
                    SRI = 1'b0;
                    SLI = 1'b0;
                end
            endcase
        end
    end

    assign CMD_READY = (state_q == ST_IDLE);
    assign DONE      = (state_q == ST_FIN);
    assign S0        = s0_q;
    assign S1        = s1_q;
    assign D         = data_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_univ_shift_ctrl.sv
// Testbench for univ_shift_ctrl: drives commands into the controller, keeps a
// behavioural model of the attached shift register, and compares timing,
// mode selects, serial fills and final register contents against values
// computed directly from the command (plain shift/rotate arithmetic).
module tb_univ_shift_ctrl;

    localparam int W  = 24;
    localparam int CW = 5;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_SHL  = 2'd1;
    localparam logic [1:0] OP_SHR  = 2'd2;
    localparam logic [1:0] OP_ASR  = 2'd3;

    logic          CK = 1'b0;
    logic          RN;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [1:0]    CMD_OP;
    logic [CW-1:0] CMD_CNT;
    logic          CMD_FILL;
    logic          CMD_ROT;
    logic [W-1:0]  LOAD_DATA;
    logic [W-1:0]  Q_IN;
    logic          S0, S1, SRI, SLI;
    logic [W-1:0]  D;
    logic          BUSY;
    logic          DONE;

    logic [W-1:0]  qReg = '0;

    int checks   = 0;
    int failures = 0;

    univ_shift_ctrl #(.C_BIT_NUM(W), .C_CNT_W(CW)) dut (
        .CK(CK), .RN(RN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_CNT(CMD_CNT), .CMD_FILL(CMD_FILL), .CMD_ROT(CMD_ROT),
        .LOAD_DATA(LOAD_DATA), .Q_IN(Q_IN), .S0(S0), .S1(S1), .SRI(SRI), .SLI(SLI),
        .D(D), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CK = ~CK;

    assign Q_IN = qReg;

    // Behavioural universal shift register driven by the controller outputs.
    always @(posedge CK) begin
        case ({S0, S1})
            2'b01:   qReg <= {qReg[W-2:0], SLI};
            2'b10:   qReg <= {SRI, qReg[W-1:1]};
            2'b11:   qReg <= D;
            default: qReg <= qReg;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit rotOn(input logic rot);
`ifdef SHIFT_ROTATE_EN
        return rot;
`else
        return 1'b0;
`endif
    endfunction

    // Expected register contents after a whole command.
    function automatic logic [W-1:0] modelResult(input logic [1:0] op, input int n,
                                                 input logic fill, input logic rot,
                                                 input logic [W-1:0] data, input logic [W-1:0] q);
        logic [2*W-1:0] w;
        logic [W-1:0]   ones;
        ones = '1;
        w    = {q, q};
        case (op)
            OP_LOAD: return data;
            OP_SHL: begin
                if (rotOn(rot)) begin
                    w = w << n;
                    return w[2*W-1:W];
                end
                return (q << n) | (fill ? (ones >> (W - n)) & ((n == 0) ? '0 : ones) : '0);
            end
            OP_SHR: begin
                if (rotOn(rot)) begin
                    w = w >> n;
                    return w[W-1:0];
                end
                return (q >> n) | (fill ? ~(ones >> n) : '0);
            end
            default: begin
                if (rotOn(rot)) begin
                    w = w >> n;
                    return w[W-1:0];
                end
                return W'($signed(q) >>> n);
            end
        endcase
    endfunction

    // Issue one command and follow it to DONE; starts and ends at a negedge.
    task automatic applyStimulus(input logic [1:0] op, input logic [CW-1:0] cnt,
                                 input logic fill, input logic rot, input logic [W-1:0] data);
        int n, active, doneAt, wait_n;
        logic [W-1:0] expQ;
        logic [1:0]   expMode;
        logic         expSli, expSri;
        n       = (op == OP_LOAD) ? 0 : ((int'(cnt) > W) ? W : int'(cnt));
        expMode = (op == OP_LOAD) ? 2'b11 : ((op == OP_SHL) ? 2'b01 : 2'b10);
        wait_n  = 0;
        while (!CMD_READY && wait_n < 100) begin
            @(negedge CK);
            wait_n++;
        end
        checkOutput("readyWait", CMD_READY, 1);
        expQ      = modelResult(op, n, fill, rot, data, qReg);
        CMD_OP    = op;
        CMD_CNT   = cnt;
        CMD_FILL  = fill;
        CMD_ROT   = rot;
        LOAD_DATA = data;
        CMD_VALID = 1'b1;
        @(posedge CK);
        #1;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'($urandom);
        CMD_CNT   = CW'($urandom);
        CMD_FILL  = 1'($urandom);
        CMD_ROT   = 1'($urandom);
        LOAD_DATA = W'($urandom);
        active = 0;
        doneAt = 0;
        for (int k = 1; k <= 40 && doneAt == 0; k++) begin
            @(negedge CK);
            if ({S0, S1} != 2'b00) begin
                active++;
                expSli = 1'b0;
                expSri = 1'b0;
                if (op == OP_SHL) expSli = rotOn(rot) ? qReg[W-1] : fill;
                if (op == OP_SHR) expSri = rotOn(rot) ? qReg[0] : fill;
                if (op == OP_ASR) expSri = rotOn(rot) ? qReg[0] : qReg[W-1];
                checkOutput("mode", {S0, S1}, expMode);
                checkOutput("busy", BUSY, 1);
                checkOutput("sli", SLI, expSli);
                checkOutput("sri", SRI, expSri);
            end else if (!DONE) begin
                checkOutput("idleGap", 1, 0);
            end
            if (DONE) begin
                doneAt = k;
                checkOutput("finBusy", BUSY, 0);
                checkOutput("finFill", {SLI, SRI}, 0);
            end
        end
        checkOutput("doneLatency", doneAt, (op == OP_LOAD) ? 2 : n + 1);
        checkOutput("activeCycles", active, (op == OP_LOAD) ? 1 : n);
        checkOutput("finalQ", qReg, expQ);
        if (op == OP_LOAD) checkOutput("dOut", D, data);
        @(negedge CK);
        checkOutput("donePulse", DONE, 0);
        checkOutput("readyBack", CMD_READY, 1);
    endtask

    // Reset in the second shift cycle must abort without a DONE.
    task automatic resetAbortTest();
        CMD_OP    = OP_SHL;
        CMD_CNT   = 5'd8;
        CMD_FILL  = 1'b1;
        CMD_ROT   = 1'b0;
        CMD_VALID = 1'b1;
        @(posedge CK);
        #1;
        CMD_VALID = 1'b0;
        @(negedge CK);
        checkOutput("rstPreBusy", BUSY, 1);
        @(posedge CK);
        #1;
        RN = 1'b0;
        @(posedge CK);
        #1;
        RN = 1'b1;
        @(negedge CK);
        checkOutput("rstMode", {S0, S1}, 0);
        checkOutput("rstBusy", BUSY, 0);
        checkOutput("rstReady", CMD_READY, 1);
        checkOutput("rstDone", DONE, 0);
        @(negedge CK);
        checkOutput("rstNoLateDone", DONE, 0);
    endtask

    // A command held valid while busy is taken only after the current DONE.
    task automatic heldValidTest();
        int accepts[$];
        int dones[$];
        int blocked;
        blocked   = 0;
        CMD_OP    = OP_SHR;
        CMD_CNT   = 5'd5;
        CMD_FILL  = 1'b0;
        CMD_ROT   = 1'b0;
        CMD_VALID = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (CMD_VALID && CMD_READY) accepts.push_back(k);
            if (CMD_VALID && !CMD_READY) blocked++;
            if (DONE) dones.push_back(k);
            @(posedge CK);
            #1;
            if (accepts.size() >= 2) CMD_VALID = 1'b0;
            @(negedge CK);
        end
        checkOutput("holdAccepts", accepts.size(), 2);
        checkOutput("holdDones", dones.size(), 2);
        checkOutput("holdBlocked", blocked, 6);
        if (accepts.size() == 2) begin
            checkOutput("holdAcc0", accepts[0], 0);
            checkOutput("holdAcc1", accepts[1], 7);
        end
        if (dones.size() == 2) begin
            checkOutput("holdDone0", dones[0], 6);
            checkOutput("holdDone1", dones[1], 13);
        end
    endtask

    initial begin
        RN        = 1'b0;
        CMD_VALID = 1'b0;
        CMD_OP    = OP_LOAD;
        CMD_CNT   = '0;
        CMD_FILL  = 1'b0;
        CMD_ROT   = 1'b0;
        LOAD_DATA = '0;
        repeat (3) @(posedge CK);
        @(negedge CK);
        checkOutput("rstReadyInit", CMD_READY, 1);
        checkOutput("rstBusyInit", BUSY, 0);
        checkOutput("rstDoneInit", DONE, 0);
        checkOutput("rstModeInit", {S0, S1}, 0);
        checkOutput("rstSerialInit", {SRI, SLI}, 0);
        checkOutput("rstDInit", D, 0);
        @(posedge CK);
        #1;
        RN = 1'b1;
        @(negedge CK);

        applyStimulus(OP_LOAD, 5'd0, 1'b0, 1'b0, 24'hA5A5A5);
        checkOutput("planLoad", qReg, 24'hA5A5A5);

        applyStimulus(OP_LOAD, 5'd0, 1'b0, 1'b0, 24'h000001);
        applyStimulus(OP_SHL, 5'd4, 1'b1, 1'b0, 24'h0);
        checkOutput("planShl", qReg, 24'h00001F);

        applyStimulus(OP_LOAD, 5'd0, 1'b0, 1'b0, 24'h800000);
        applyStimulus(OP_ASR, 5'd3, 1'b0, 1'b0, 24'h0);
        checkOutput("planAsr", qReg, 24'hF00000);

        applyStimulus(OP_SHR, 5'd0, 1'b1, 1'b0, 24'h0);
        checkOutput("planShr0", qReg, 24'hF00000);

        applyStimulus(OP_LOAD, 5'd0, 1'b0, 1'b0, 24'hC3C3C3);
        applyStimulus(OP_SHR, 5'd30, 1'b0, 1'b0, 24'h0);
        checkOutput("planShr30", qReg, 24'h000000);

        applyStimulus(OP_LOAD, 5'd0, 1'b0, 1'b0, 24'h800001);
        applyStimulus(OP_SHL, 5'd1, 1'b0, 1'b1, 24'h0);
`ifdef SHIFT_ROTATE_EN
        checkOutput("planRot", qReg, 24'h000003);
`else
        checkOutput("planRot", qReg, 24'h000002);
`endif

        resetAbortTest();
        heldValidTest();

        for (int i = 0; i < 40; i++) begin
            if (i % 6 == 0) begin
                applyStimulus(OP_LOAD, 5'd0, 1'b0, 1'b0, W'($urandom));
            end else begin
                applyStimulus(2'($urandom_range(0, 3)), CW'($urandom_range(0, 31)),
                              1'($urandom), 1'($urandom), W'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
